seq_core_ctrl: RTL
==================

Name: seq_core_ctrl

Overview:
- Parametrised multi-cycle sequencing controller for the core: owns PC, instruction register, phase FSM and data-bus handshake.
- Adds precise trap entry on page faults and bus timeouts, EPC/cause capture, eret return and double-fault halt.
- Sits between the decoder/ALU/regfile datapath and the DataBus master port.

Parameters:
- ADDR_W, 32, width of PC, bus address, EPC.
- RESET_PC, 0, PC loaded on reset.
- TRAP_VECTOR, 32'h80, PC loaded on trap entry.
- TIMEOUT_CYC, 255, wait cycles without ready before bus-timeout trap (1..65535).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- res  in  1  asynchronous active-low reset.
- dec_read  in  1  decoded instruction is a load.
- dec_write  in  1  decoded instruction is a store.
- dec_wreg  in  1  decoded instruction writes a register.
- dec_eret  in  1  decoded instruction is eret.
- dec_memtype  in  2  data access size from decoder.
- next_pc  in  ADDR_W  sequential/branch target from fetch unit.
- alu_addr  in  ADDR_W  effective data address.
- bus_din  in  32  read data from bus.
- bus_ready  in  1  bus access complete this cycle.
- page_fault  in  1  MMU fault for the current bus access.
- bus_read  out  1  read strobe (FETCH or READMEM).
- bus_write  out  1  write strobe (WRITEMEM).
- bus_addr  out  ADDR_W  pc in FETCH, else alu_addr.
- bus_memtype  out  2  WORD(2'd2) in FETCH, else dec_memtype.
- ins  out  32  instruction register.
- pc  out  ADDR_W  current PC.
- reg_we  out  1  regfile write enable.
- reg_src_mem  out  1  1 = write data from bus_din (WRITEBACK).
- epc  out  ADDR_W  PC of faulting instruction.
- cause  out  3  trap cause code.
- halted  out  1  double-fault halt.
- perf_cycles  out  32  cycle counter (optional feature).
- perf_retired  out  32  retired-instruction counter (optional feature).

Behaviour:
- Reset (res low, async): state INIT, pc=RESET_PC, ins=0, epc=0, cause=0, in_trap=0, halted=0, wait counter=0, perf counters=0.
- All bus_* and reg_* outputs are combinational decodes of state; in INIT, TRAP and HALT they are all 0.
- States and transitions:
  - INIT -> FETCH.
  - FETCH: page_fault -> trap(cause 1). Else if bus_ready, ins<=bus_din, go to EXEC.
  - EXEC: dec_eret -> pc<=epc, in_trap<=0, go to FETCH. Else if dec_read, go to READMEM. Else if dec_write, go to WRITEMEM. Else pc<=next_pc, go to FETCH.
  - READMEM: page_fault -> trap(cause 2). Else if bus_ready, go to WRITEBACK.
  - WRITEMEM: page_fault -> trap(cause 3). Else if bus_ready, pc<=next_pc, go to FETCH.
  - WRITEBACK: pc<=next_pc, go to FETCH.
  - TRAP (one cycle): pc<=TRAP_VECTOR, go to FETCH.
  - HALT: absorbing; only reset exits.
- reg_we: asserted in EXEC when dec_wreg & !dec_read & !dec_write & !dec_eret, and in WRITEBACK when dec_wreg.
- Trap entry: epc<=pc (address of faulting instruction, not next_pc), cause<=code, in_trap<=1, go to TRAP.
- Double fault: trap condition while in_trap=1 -> HALT with halted=1; epc and cause are left unchanged.
- Simultaneous page_fault and bus_ready: the fault wins; ins is not loaded and no state advance occurs.
- Wait counter: counts consecutive FETCH/READMEM/WRITEMEM cycles with bus_ready=0 and no fault. Clears on any state change.
- Timeout: when the counter equals TIMEOUT_CYC-1 and bus_ready is still 0, trap with cause 4, taking priority after page_fault. bus_ready on the cycle the counter reaches TIMEOUT_CYC-1 completes normally.
- Cause codes: 0 none, 1 ifetch fault, 2 load fault, 3 store fault, 4 bus timeout.
- pc increments never occur from this block; next_pc is taken verbatim, so wrap-around is the fetch unit's responsibility.

Optional Feature:
- Macro SEQ_CORE_PERF_CNT_EN.
- Defined: perf_cycles increments every cycle outside reset and HALT. perf_retired increments on each transition into FETCH from EXEC, WRITEMEM or WRITEBACK, and on eret; trap entries do not count. Both wrap modulo 2^32.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ALU op, ready immediate: reset with RESET_PC=0, ins=add, next_pc=4 -> sequence INIT, FETCH, EXEC, FETCH; reg_we=1 for exactly one cycle; pc=4.
- Load: dec_read=1, alu_addr=0x100, ready after 2 waits -> bus_addr=0x100, bus_read high for 3 cycles, then WRITEBACK with reg_we=1 and reg_src_mem=1; pc=next_pc.
- Store page fault: pc=0x40, dec_write=1, page_fault in WRITEMEM -> epc=0x40, cause=3, TRAP for one cycle, then FETCH at 0x80; bus_write deasserted.
- Bus timeout: TIMEOUT_CYC=4, bus_ready held 0 in FETCH -> TRAP entered after the 4th wait cycle with cause=4; ready pulsed on the 4th cycle instead -> normal EXEC.
- Double fault and eret: fault then fault again inside the handler -> halted=1 and bus idle until res low. Fault, then eret -> pc=epc and in_trap cleared, so a later fault traps normally.
- Reset mid-load: res low during READMEM -> outputs 0 immediately (async); after release, fetch resumes from RESET_PC. With SEQ_CORE_PERF_CNT_EN defined, perf_retired=2 after two ALU instructions.

Source files
------------

// File: rtl/seq_core_ctrl_if.sv
// Data-bus handshake between the sequencing controller (master) and the
// memory system (slave): strobes, address and size out; data, ready and
// MMU fault back.
interface seq_core_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_read;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_memtype;
  logic [31:0]       bus_din;
  logic              bus_ready;
  logic              page_fault;

  modport master (
    output bus_read, bus_write, bus_addr, bus_memtype,
    input  bus_din, bus_ready, page_fault
  );

  modport slave (
    input  bus_read, bus_write, bus_addr, bus_memtype,
    output bus_din, bus_ready, page_fault
  );
endinterface

// File: rtl/seq_core_ctrl.sv
// Multi-cycle sequencing controller: PC, instruction register, phase FSM,
// data-bus handshake, precise traps (page fault / bus timeout), EPC/cause
// capture, eret return and double-fault halt.
// Optional performance counters are built when SEQ_CORE_PERF_CNT_EN is defined.
module seq_core_ctrl #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 32'h80,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              res,
  input  logic              dec_read,
  input  logic              dec_write,
  input  logic              dec_wreg,
  input  logic              dec_eret,
  input  logic [1:0]        dec_memtype,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic [ADDR_W-1:0] alu_addr,
  seq_core_ctrl_if.master   bus,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] pc,
  output logic              reg_we,
  output logic              reg_src_mem,
  output logic [ADDR_W-1:0] epc,
  output logic [2:0]        cause,
  output logic              halted,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_retired
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_EXEC, S_READMEM, S_WRITEMEM, S_WRITEBACK, S_TRAP, S_HALT
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  MT_WORD   = 2'd2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [31:0]       ins_q, ins_d;
  logic [2:0]        cause_q, cause_d;
  logic              in_trap_q, in_trap_d;
  logic              halted_q, halted_d;
  logic [15:0]       wait_q, wait_d;
  logic              trap_req;
  logic [2:0]        trap_code;
  logic              bus_state;

  // State and architectural registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_INIT;
      pc_q      <= RESET_PC;
      ins_q     <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      in_trap_q <= 1'b0;
      halted_q  <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      in_trap_q <= in_trap_d;
      halted_q  <= halted_d;
      wait_q    <= wait_d;
    end
  end

  // Next state: phase sequencing, trap/double-fault resolution, wait counter
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    in_trap_d = in_trap_q;
    halted_d  = halted_q;
    trap_req  = 1'b0;
    trap_code = 3'd0;
    bus_state = (state_q == S_FETCH) || (state_q == S_READMEM) || (state_q == S_WRITEMEM);

    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.page_fault) begin
          trap_req  = 1'b1;
          trap_code = 3'd1;
        end else if (bus.bus_ready) begin
          ins_d   = bus.bus_din;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          trap_req  = 1'b1;
          trap_code = 3'd4;
        end
      end
      S_EXEC: begin
        if (dec_eret) begin
          pc_d      = epc_q;
          in_trap_d = 1'b0;
          state_d   = S_FETCH;
        end else if (dec_read) begin
          state_d = S_READMEM;
        end else if (dec_write) begin
          state_d = S_WRITEMEM;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_READMEM: begin
        if (bus.page_fault) begin
          trap_req  = 1'b1;
          trap_code = 3'd2;
        end else if (bus.bus_ready) begin
          state_d = S_WRITEBACK;
        end else if (wait_q == WAIT_LAST) begin
          trap_req  = 1'b1;
          trap_code = 3'd4;
        end
      end
      S_WRITEMEM: begin
        if (bus.page_fault) begin
          trap_req  = 1'b1;
          trap_code = 3'd3;
        end else if (bus.bus_ready) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          trap_req  = 1'b1;
          trap_code = 3'd4;
        end
      end
      S_WRITEBACK: begin
        pc_d    = next_pc;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase

    // A trap raised inside the handler halts and keeps the first EPC/cause.
    if (trap_req) begin
      if (in_trap_q) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else begin
        epc_d     = pc_q;
        cause_d   = trap_code;
        in_trap_d = 1'b1;
        state_d   = S_TRAP;
      end
    end

    // Staying in a bus state implies no ready, no fault and no timeout.
    wait_d = (bus_state && (state_d == state_q)) ? wait_q + 16'd1 : '0;
  end

  // Output decode of the current phase
  always_comb begin
    bus.bus_read    = 1'b0;
    bus.bus_write   = 1'b0;
    bus.bus_addr    = '0;
    bus.bus_memtype = 2'd0;
    reg_we          = 1'b0;
    reg_src_mem     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.bus_read    = 1'b1;
        bus.bus_addr    = pc_q;
        bus.bus_memtype = MT_WORD;
      end
      S_EXEC: begin
        bus.bus_addr    = alu_addr;
        bus.bus_memtype = dec_memtype;
        reg_we          = dec_wreg & ~dec_read & ~dec_write & ~dec_eret;
      end
      S_READMEM: begin
        bus.bus_read    = 1'b1;
        bus.bus_addr    = alu_addr;
        bus.bus_memtype = dec_memtype;
      end
      S_WRITEMEM: begin
        bus.bus_write   = 1'b1;
        bus.bus_addr    = alu_addr;
        bus.bus_memtype = dec_memtype;
      end
      S_WRITEBACK: begin
        bus.bus_addr    = alu_addr;
        bus.bus_memtype = dec_memtype;
        reg_we          = dec_wreg;
        reg_src_mem     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ins    = ins_q;
  assign pc     = pc_q;
  assign epc    = epc_q;
  assign cause  = cause_q;
  assign halted = halted_q;

`ifdef SEQ_CORE_PERF_CNT_EN
  logic [31:0] perf_cyc_q, perf_cyc_d, perf_ret_q, perf_ret_d;
  logic        retire;

  // Active-cycle and retired-instruction counts (traps do not retire)
  always_comb begin
    retire     = (state_d == S_FETCH) &&
                 ((state_q == S_EXEC) || (state_q == S_WRITEMEM) || (state_q == S_WRITEBACK));
    perf_cyc_d = (state_q != S_HALT) ? perf_cyc_q + 32'd1 : perf_cyc_q;
    perf_ret_d = retire ? perf_ret_q + 32'd1 : perf_ret_q;
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      perf_cyc_q <= '0;
      perf_ret_q <= '0;
    end else begin
      perf_cyc_q <= perf_cyc_d;
      perf_ret_q <= perf_ret_d;
    end
  end

  assign perf_cycles  = perf_cyc_q;
  assign perf_retired = perf_ret_q;
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule
